sram32k_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 32K x 8 single-port block-RAM macro (two 16K banks selected by address bit 14, bypass read mode, 1-cycle read latency).
- Grants one requester at a time using round-robin priority.
- Drives the macro's ce/wre/ad/din.
- Captures read data and returns a single-cycle ack per transaction.
- Sits between the CPU-side port (port 0) and the loader/DMA port (port 1).

---
 rtl/sram32k_arbiter_if.sv | 48 ++++
 rtl/sram32k_arbiter.sv | 104 ++++++++++
 tb/tb_sram32k_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram32k_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 32K x 8 macro.
// The arbiter uses the slave view; requesters and the macro model use master.
interface sram32k_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              ram_ce;
    logic              ram_oce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              busy;
    logic              grant;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_dout,
        output ack0, rdata0, ack1, rdata1,
        output ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
        output busy, grant
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_dout,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
        input  busy, grant
    );
endinterface

// File: rtl/sram32k_arbiter.sv
// Round-robin two-port arbiter and sequencer for the 32K x 8 block-RAM macro.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x READ_LAT) -> ACK.
module sram32k_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    sram32k_arbiter_if.slave bus
);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             state;
    state_t             state_nx;
    logic               ptr;
    logic               lat_we;
    logic [CNT_W-1:0]   cnt;
    logic               go;
    logic               sel;

    if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_lat
        $error("READ_LAT must be 1..3");
    end

    assign bus.ram_oce = 1'b1;

    // Next state and grant choice; requests are only looked at in IDLE.
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        sel      = (bus.req0 && bus.req1) ? ptr : bus.req1;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    go       = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = lat_we ? ACK : WAIT;
            WAIT: begin
                if (cnt == CNT_W'(1)) state_nx = ACK;
            end
            ACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Registered macro drive, read capture, acks and the priority pointer.
    // ram_ad/ram_din double as the latched address and write data: they are
    // loaded on the grant and simply hold until the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            bus.ram_ce  <= 1'b0;
            bus.ram_wre <= 1'b0;
            bus.ram_ad  <= '0;
            bus.ram_din <= '0;
            bus.busy    <= 1'b0;
            bus.grant   <= 1'b0;
            ptr         <= 1'b0;
            lat_we      <= 1'b0;
            cnt         <= '0;
        end else begin
            bus.ram_ce  <= 1'b0;
            bus.ram_wre <= 1'b0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.busy    <= (state_nx != IDLE);
            if (go) begin
                bus.grant   <= sel;
                lat_we      <= sel ? bus.we1 : bus.we0;
                bus.ram_ce  <= 1'b1;
                bus.ram_wre <= sel ? bus.we1 : bus.we0;
                bus.ram_ad  <= sel ? bus.addr1 : bus.addr0;
                bus.ram_din <= sel ? bus.wdata1 : bus.wdata0;
            end
            if (state == ISSUE && !lat_we) cnt <= CNT_W'(READ_LAT);
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    if (bus.grant) bus.rdata1 <= bus.ram_dout;
                    else           bus.rdata0 <= bus.ram_dout;
                end
            end
            if (state != ACK && state_nx == ACK) begin
                bus.ack0 <= ~bus.grant;
                bus.ack1 <= bus.grant;
            end
            if (state == ACK) ptr <= ~bus.grant;
        end
    end
endmodule

// File: tb/tb_sram32k_arbiter.sv
// Scoreboard bench for sram32k_arbiter with a behavioural 32K x 8 macro.
// Drivers queue expected transactions; a negedge monitor checks every ack.
module tb_sram32k_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int RL = 1;

    typedef struct {
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sram32k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram32k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    logic [DW-1:0] ram [32768];
    logic [DW-1:0] model [32768];
    logic [DW-1:0] pipe [RL];
    logic [DW-1:0] exp_rd [2];
    txn_t q0[$];
    txn_t q1[$];
    int   order[$];
    int   total = 0;
    int   bad = 0;
    int   ce_cnt = 0;
    int   ack_cnt = 0;

    function automatic logic [DW-1:0] init_val(int i);
        return DW'(i * 37 + 11);
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]   = init_val(i);
            model[i] = init_val(i);
        end
    end

    // Macro model: registered output, READ_LAT stages from ce to dout.
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_wre) ram[bus.ram_ad] = bus.ram_din;
            else             pipe[0] <= ram[bus.ram_ad];
        end
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ram_dout = pipe[RL-1];

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic on_ack(int p);
        txn_t t;
        int   o;
        o = 1 - p;
        ack_cnt++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL spurious_ack: port %0d acked, no request pending", p);
            return;
        end
        t = (p == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_grant", 32'(bus.grant), 32'(p));
        chk("ce_per_txn", 32'(ce_cnt), 32'(ack_cnt));
        if (t.we) begin
            model[t.a] = t.d;
        end else begin
            chk("rdata", p ? bus.rdata1 : bus.rdata0, model[t.a]);
            exp_rd[p] = model[t.a];
        end
        chk("other_rdata", o ? bus.rdata1 : bus.rdata0, exp_rd[o]);
        order.push_back(p);
    endtask

    // Monitor: checks macro drive in ISSUE and every ack against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_ce) begin
                ce_cnt++;
                if (bus.grant == 1'b0 && q0.size() > 0) begin
                    chk("issue_ad0", 32'(bus.ram_ad), 32'(q0[0].a));
                    chk("issue_we0", 32'(bus.ram_wre), 32'(q0[0].we));
                    if (q0[0].we) chk("issue_din0", bus.ram_din, q0[0].d);
                end
                if (bus.grant == 1'b1 && q1.size() > 0) begin
                    chk("issue_ad1", 32'(bus.ram_ad), 32'(q1[0].a));
                    chk("issue_we1", 32'(bus.ram_wre), 32'(q1[0].we));
                    if (q1[0].we) chk("issue_din1", bus.ram_din, q1[0].d);
                end
            end
            if (bus.ack0 || bus.ack1)
                chk("single_ack", 32'(bus.ack0 & bus.ack1), 0);
            if (bus.ack0) on_ack(0);
            if (bus.ack1) on_ack(1);
        end
    end

    // Called at posedge+1; lat >= 0 checks req-to-ack cycles.
    task automatic txn(int p, bit we, logic [AW-1:0] a, logic [DW-1:0] d,
                       int lat);
        txn_t t;
        int   n;
        bit   seen;
        t = '{we, a, d};
        if (p == 0) begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
            q0.push_back(t);
        end else begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
            q1.push_back(t);
        end
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            n++;
            seen = p ? bus.ack1 : bus.ack0;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: port %0d no ack in 64 cycles", p);
        end else if (lat >= 0) begin
            chk("latency", 32'(n - 1), 32'(lat));
        end
        @(posedge clk);
        #1;
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    // Called at a negedge; leaves the bench at posedge+1 with reset released.
    task automatic hit_reset();
        reset_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        chk("rst_ack0", 32'(bus.ack0), 0);
        chk("rst_ack1", 32'(bus.ack1), 0);
        chk("rst_rdata0", 32'(bus.rdata0), 0);
        chk("rst_rdata1", 32'(bus.rdata1), 0);
        chk("rst_ce", 32'(bus.ram_ce), 0);
        chk("rst_wre", 32'(bus.ram_wre), 0);
        chk("rst_ad", 32'(bus.ram_ad), 0);
        chk("rst_din", 32'(bus.ram_din), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("oce", 32'(bus.ram_oce), 1);
        q0.delete();
        q1.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        ce_cnt = 0;
        ack_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 15'h0000;
            1:       return 15'h3FFF;
            2:       return 15'h4000;
            3:       return 15'h7FFF;
            4:       return 15'h0050;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic rand_port(int p, int cnt);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            txn(p, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom), -1);
        end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        hit_reset();

        // Port 0 write then read back.
        txn(0, 1'b1, 15'h0123, 8'hA5, 2);
        txn(0, 1'b0, 15'h0123, 8'h00, 2 + RL);
        chk("p0_readback", 32'(bus.rdata0), 32'h A5);

        // Port 1 across the bank boundary.
        txn(1, 1'b1, 15'h3FFF, 8'h11, 2);
        txn(1, 1'b1, 15'h4000, 8'h22, 2);
        txn(1, 1'b0, 15'h3FFF, 8'h00, 2 + RL);
        chk("bank_lo", 32'(bus.rdata1), 32'h11);
        txn(1, 1'b0, 15'h4000, 8'h00, 2 + RL);
        chk("bank_hi", 32'(bus.rdata1), 32'h22);

        // Continuous contention: strict alternation from port 0.
        order.delete();
        fork
            for (int i = 0; i < 4; i++)
                txn(0, 1'b0, AW'(16'h0200 + i), 8'h00, -1);
            for (int i = 0; i < 4; i++)
                txn(1, 1'b0, AW'(16'h5300 + i), 8'h00, -1);
        join
        chk("alt_len", 32'(order.size()), 8);
        for (int i = 0; i < order.size() && i < 8; i++)
            chk("alt_order", 32'(order[i]), 32'(i % 2));

        // Reset during the WAIT of a port 1 read.
        bus.we1 = 1'b0; bus.addr1 = 15'h0777; bus.req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_issue_ce", 32'(bus.ram_ce), 1);
        @(negedge clk);
        chk("mid_wait_busy", 32'(bus.busy), 1);
        hit_reset();
        repeat (3) @(posedge clk);
        #1;
        txn(1, 1'b0, 15'h0777, 8'h00, 2 + RL);
        chk("post_rst_read", 32'(bus.rdata1), 32'(init_val(16'h0777)));

        // Same-cycle read/write to one address: port 0 favoured, old data.
        order.delete();
        fork
            txn(0, 1'b0, 15'h0050, 8'h00, -1);
            txn(1, 1'b1, 15'h0050, 8'h7E, -1);
        join
        chk("conflict_first", 32'(order.size() > 0 ? order[0] : 9), 0);
        chk("conflict_old", 32'(bus.rdata0), 32'(init_val(16'h0050)));
        txn(0, 1'b0, 15'h0050, 8'h00, 2 + RL);
        chk("conflict_new", 32'(bus.rdata0), 32'h7E);

        // Randomised mixed traffic on both ports.
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
